pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Parametrised pipeline control unit for the 5-stage MIPS core, replacing the fixed lock/clear generator and the separate forwarding stub.
- Drives per-register write-enable and synchronous-clear vectors and the PC write-enable.
- Produces EX-stage forwarding selects.
- Sequences load-use stalls, taken-branch flushes and multi-cycle EX-unit stalls through a registered FSM.
- Keeps saturating stall/flush performance counters.

Parameters:
AW, 5, register address width
NREG, 4, number of pipeline registers (index 0 = IF/ID ... NREG-1 = MEM/WB)
BR_FLUSH, 3, number of youngest pipeline registers cleared on a taken branch (1..NREG-1)
MC_MAX, 32, EX busy cycles tolerated before timeout
CNT_W, 16, performance counter width

Ports:
clock  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
branch_taken  in  1  taken branch resolved in MEM this cycle
id_rs  in  AW  rs field of the instruction in IF/ID
id_rt  in  AW  rt field of the instruction in IF/ID
ex_rs  in  AW  rs of the instruction in ID/EX
ex_rt  in  AW  rt of the instruction in ID/EX
ex_memread  in  1  instruction in ID/EX is a load
ex_busy  in  1  multi-cycle EX unit not done
exm_regw  in  1  EX/MEM RegWrite
exm_rd  in  AW  EX/MEM destination
mwb_regw  in  1  MEM/WB RegWrite
mwb_rd  in  AW  MEM/WB destination
pc_write  out  1  1 = PC updates
pipe_write  out  NREG  bit i = 1: register i captures its inputs
pipe_clear  out  NREG  bit i = 1: register i loads a bubble (all zero) at the edge
fwd_a  out  2  ALU A select: 00 GPR, 01 EX/MEM aluOut, 10 WB writeback
fwd_b  out  2  same for ALU B / store data
mc_abort  out  1  one-cycle pulse: squash the multi-cycle op in flight
mc_timeout  out  1  sticky error flag
stall_cnt  out  CNT_W  cycles with pc_write = 0
flush_cnt  out  CNT_W  number of taken-branch flushes

Behaviour:
- FSM states: RUN, LOAD_STALL, MC_STALL, FLUSH.
- Reset drives the FSM to RUN; clears stall_cnt, flush_cnt, mc_timeout and the busy counter.
- Outputs during a reset cycle:
  - pipe_clear and pipe_write: all ones
  - pc_write = 1
  - fwd_a and fwd_b = 00
  - mc_abort = 0
- Default (RUN, no event): pipe_write all ones, pipe_clear all zeros, pc_write = 1.
- Event detection is combinational from the current inputs. Priority: branch_taken > ex_busy > load-use.
- Taken branch (branch_taken = 1):
  - pipe_clear[BR_FLUSH-1:0] = 1; pc_write = 1 (PC loads the branch target).
  - flush_cnt increments.
  - Next state is FLUSH for exactly one cycle. In FLUSH, load-use and busy detection are suppressed and the outputs are the default outputs; then RUN.
  - If ex_busy = 1 in the same cycle, mc_abort pulses and the busy counter clears.
- Multi-cycle EX (ex_busy = 1, no branch):
  - pc_write = 0; pipe_write[1:0] = 0.
  - pipe_clear[2] = 1 (bubble into EX/MEM); MEM/WB advances.
  - State is MC_STALL while busy. The busy counter increments each busy cycle.
  - When the counter reaches MC_MAX, mc_timeout sets (sticky until reset) and the stall continues.
  - Deassertion of ex_busy returns the FSM to RUN the next cycle and clears the busy counter.
- Load-use condition: ex_memread & ex_rt != 0 & (ex_rt == id_rs | ex_rt == id_rt).
  - Response: pc_write = 0, pipe_write[0] = 0, pipe_clear[1] = 1.
  - Next state is LOAD_STALL for one cycle; load-use detection is masked in that cycle, then RUN.
  - Exactly one bubble is inserted per load.
- stall_cnt increments in every cycle with pc_write = 0. Both counters saturate at all ones.
- Forwarding (fwd_a from ex_rs; fwd_b identically from ex_rt):
  - 01 if exm_regw & exm_rd != 0 & exm_rd == ex_rs;
  - else 10 if mwb_regw & mwb_rd != 0 & mwb_rd == ex_rs;
  - else 00.
  - Register 0 is never forwarded.
- Reset mid-stall or mid-flush: reset wins, and the next cycle is RUN with default outputs.

Test Plan:
- lw $2 in ID/EX (ex_memread = 1, ex_rt = 2), add using id_rs = 2 -> one cycle with pc_write = 0, pipe_write = 1110, pipe_clear = 0010; next cycle defaults; stall_cnt = 1.
- branch_taken = 1 with BR_FLUSH = 3 -> pipe_clear = 0111, pc_write = 1, flush_cnt = 1; following cycle is default even if load-use inputs are present.
- ex_busy high for 5 cycles -> 5 cycles of pc_write = 0, pipe_write = 1100, pipe_clear = 0100; stall_cnt = 5; mc_timeout = 0; RUN on the 6th cycle.
- ex_busy held 40 cycles with MC_MAX = 32 -> mc_timeout rises after the 32nd busy cycle and stays 1 until reset; simultaneous branch_taken -> mc_abort is a 1-cycle pulse.
- exm_rd = mwb_rd = 3, both regw = 1, ex_rs = 3 -> fwd_a = 01; exm_regw = 0 -> fwd_a = 10; ex_rs = 0 with rd = 0 -> fwd_a = 00.
- CNT_W = 4: force 20 stall cycles -> stall_cnt saturates at 15; assert reset during MC_STALL -> counters and mc_timeout return to 0, state RUN.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - hazard controller signal bundle between core datapath and control unit
interface pipeline_hazard_ctrl_if #(
    parameter int AW    = 5,
    parameter int NREG  = 4,
    parameter int CNT_W = 16
);
    logic             branch_taken;
    logic [AW-1:0]    id_rs;
    logic [AW-1:0]    id_rt;
    logic [AW-1:0]    ex_rs;
    logic [AW-1:0]    ex_rt;
    logic             ex_memread;
    logic             ex_busy;
    logic             exm_regw;
    logic [AW-1:0]    exm_rd;
    logic             mwb_regw;
    logic [AW-1:0]    mwb_rd;
    logic             pc_write;
    logic [NREG-1:0]  pipe_write;
    logic [NREG-1:0]  pipe_clear;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             mc_abort;
    logic             mc_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output branch_taken, id_rs, id_rt, ex_rs, ex_rt, ex_memread, ex_busy,
               exm_regw, exm_rd, mwb_regw, mwb_rd,
        input  pc_write, pipe_write, pipe_clear, fwd_a, fwd_b, mc_abort,
               mc_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  branch_taken, id_rs, id_rt, ex_rs, ex_rt, ex_memread, ex_busy,
               exm_regw, exm_rd, mwb_regw, mwb_rd,
        output pc_write, pipe_write, pipe_clear, fwd_a, fwd_b, mc_abort,
               mc_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 5-stage pipeline stall/flush sequencer, forwarding selects and perf counters
module pipeline_hazard_ctrl #(
    parameter int AW       = 5,
    parameter int NREG     = 4,
    parameter int BR_FLUSH = 3,
    parameter int MC_MAX   = 32,
    parameter int CNT_W    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {RUN, LOAD_STALL, MC_STALL, FLUSH} state_t;

    localparam int BW = $clog2(MC_MAX + 1);
    localparam logic [BW-1:0] MC_TOP  = BW'(MC_MAX);
    localparam logic [BW-1:0] MC_LAST = BW'(MC_MAX - 1);

    state_t           state, state_nxt;
    logic [BW-1:0]    busy_cnt;
    logic             mc_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    logic             load_use, ev_branch, ev_busy, ev_load;
    logic             pc_write_c, mc_abort_c;
    logic [NREG-1:0]  pipe_write_c, pipe_clear_c;
    logic [1:0]       fwd_a_c, fwd_b_c;

    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src);
        if (hz.exm_regw && hz.exm_rd != '0 && hz.exm_rd == src)
            return 2'b01;
        else if (hz.mwb_regw && hz.mwb_rd != '0 && hz.mwb_rd == src)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    // FLUSH masks everything; LOAD_STALL masks only a repeat load-use so one bubble is inserted per load
    always_comb begin
        load_use  = hz.ex_memread && hz.ex_rt != '0 &&
                    (hz.ex_rt == hz.id_rs || hz.ex_rt == hz.id_rt);
        ev_branch = (state != FLUSH) && hz.branch_taken;
        ev_busy   = (state != FLUSH) && hz.ex_busy && !hz.branch_taken;
        ev_load   = (state == RUN || state == MC_STALL) && load_use &&
                    !hz.branch_taken && !hz.ex_busy;
    end

    always_comb begin
        state_nxt    = RUN;
        pc_write_c   = 1'b1;
        pipe_write_c = '1;
        pipe_clear_c = '0;
        mc_abort_c   = 1'b0;
        fwd_a_c      = 2'b00;
        fwd_b_c      = 2'b00;
        if (reset) begin
            pipe_clear_c = '1;
        end else begin
            fwd_a_c = fwd_sel(hz.ex_rs);
            fwd_b_c = fwd_sel(hz.ex_rt);
            if (ev_branch) begin
                for (int i = 0; i < BR_FLUSH; i++)
                    pipe_clear_c[i] = 1'b1;
                mc_abort_c = hz.ex_busy;
                state_nxt  = FLUSH;
            end else if (ev_busy) begin
                pc_write_c      = 1'b0;
                pipe_write_c[0] = 1'b0;
                pipe_write_c[1] = 1'b0;
                pipe_clear_c[2] = 1'b1;
                state_nxt       = MC_STALL;
            end else if (ev_load) begin
                pc_write_c      = 1'b0;
                pipe_write_c[0] = 1'b0;
                pipe_clear_c[1] = 1'b1;
                state_nxt       = LOAD_STALL;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= RUN;
            busy_cnt   <= '0;
            mc_timeout <= 1'b0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (!pc_write_c && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (ev_branch && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
            // an aborted op restarts its timeout budget from zero
            if (ev_branch || !hz.ex_busy)
                busy_cnt <= '0;
            else if (ev_busy && busy_cnt != MC_TOP)
                busy_cnt <= busy_cnt + 1'b1;
            if (ev_busy && busy_cnt == MC_LAST)
                mc_timeout <= 1'b1;
        end
    end

    assign hz.pc_write   = pc_write_c;
    assign hz.pipe_write = pipe_write_c;
    assign hz.pipe_clear = pipe_clear_c;
    assign hz.fwd_a      = fwd_a_c;
    assign hz.fwd_b      = fwd_b_c;
    assign hz.mc_abort   = mc_abort_c;
    assign hz.mc_timeout = mc_timeout;
    assign hz.stall_cnt  = stall_cnt;
    assign hz.flush_cnt  = flush_cnt;
endmodule
